// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// ram_arbiter : round-robin sharer of the single-port RAM (CPU bus A, loader B)
// Optional macro RAM_ARBITER_STATS_EN adds grant/conflict counters. Rev 1.0
// ============================================================================
module ram_arbiter #(
  parameter int RAM_DEPTH  = 16,
  parameter int WIDTH      = 8,
  parameter int MAX_LOCK   = 4,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  i_a_req,
  input  logic                  i_a_lock,
  input  logic                  i_a_we,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [WIDTH-1:0]      i_a_wdata,
  input  logic                  i_b_req,
  input  logic                  i_b_lock,
  input  logic                  i_b_we,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [WIDTH-1:0]      i_b_wdata,
  output logic                  o_a_gnt,
  output logic                  o_b_gnt,
  output logic [WIDTH-1:0]      o_a_rdata,
  output logic [WIDTH-1:0]      o_b_rdata,
  output logic                  o_a_rvalid,
  output logic                  o_b_rvalid,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic                  o_ram_load_enable,
  output logic [WIDTH-1:0]      o_ram_load_data,
  input  logic [WIDTH-1:0]      i_ram_data
`ifdef RAM_ARBITER_STATS_EN
  ,
  output logic [15:0]           o_a_grant_count,
  output logic [15:0]           o_b_grant_count,
  output logic [15:0]           o_conflict_count
`endif
);

  localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    last_b;      // 1 when B received the most recent grant
  logic                    last_b_nxt;
  logic [CNT_W-1:0]        lock_cnt;
  logic [CNT_W-1:0]        lock_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   addr_hold;
  logic                    a_gnt;
  logic                    b_gnt;
  logic                    a_rd;
  logic                    b_rd;

  assign a_gnt = (state == OWN_A) && i_a_req;
  assign b_gnt = (state == OWN_B) && i_b_req;
  assign a_rd  = a_gnt && !i_a_we;
  assign b_rd  = b_gnt && !i_b_we;

  always_comb begin
    state_nxt    = state;
    last_b_nxt   = last_b;
    lock_cnt_nxt = '0;
    case (state)
      IDLE: begin
        if (i_a_req && i_b_req) begin
          state_nxt = last_b ? OWN_A : OWN_B;
        end else if (i_a_req) begin
          state_nxt = OWN_A;
        end else if (i_b_req) begin
          state_nxt = OWN_B;
        end
      end
      OWN_A: begin
        if (i_a_req) begin
          if (i_a_lock && i_b_req) begin
            if (lock_cnt < LOCK_LAST) begin
              lock_cnt_nxt = lock_cnt + 1'b1;
            end else begin
              state_nxt = OWN_B;
            end
          end else if (!i_a_lock && i_b_req) begin
            state_nxt = OWN_B;
          end
        end else begin
          state_nxt = i_b_req ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (i_b_req) begin
          if (i_b_lock && i_a_req) begin
            if (lock_cnt < LOCK_LAST) begin
              lock_cnt_nxt = lock_cnt + 1'b1;
            end else begin
              state_nxt = OWN_A;
            end
          end else if (!i_b_lock && i_a_req) begin
            state_nxt = OWN_A;
          end
        end else begin
          state_nxt = i_a_req ? OWN_A : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (a_gnt) begin
      last_b_nxt = 1'b0;
    end
    if (b_gnt) begin
      last_b_nxt = 1'b1;
    end
  end

  // IDLE presents the address last used by an owner so the RAM output stays stable
  assign o_ram_address     = (state == OWN_A) ? i_a_addr :
                             (state == OWN_B) ? i_b_addr : addr_hold;
  assign o_ram_load_data   = (state == OWN_B) ? i_b_wdata : i_a_wdata;
  assign o_ram_load_enable = (a_gnt && i_a_we) || (b_gnt && i_b_we);
  assign o_a_gnt           = a_gnt;
  assign o_b_gnt           = b_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      lock_cnt   <= '0;
      addr_hold  <= '0;
      o_a_rdata  <= '0;
      o_b_rdata  <= '0;
      o_a_rvalid <= 1'b0;
      o_b_rvalid <= 1'b0;
    end else if (clk_en) begin
      state      <= state_nxt;
      last_b     <= last_b_nxt;
      lock_cnt   <= lock_cnt_nxt;
      o_a_rvalid <= a_rd;
      o_b_rvalid <= b_rd;
      if (a_rd) begin
        o_a_rdata <= i_ram_data;
      end
      if (b_rd) begin
        o_b_rdata <= i_ram_data;
      end
      if (state != IDLE) begin
        addr_hold <= o_ram_address;
      end
    end
  end

`ifdef RAM_ARBITER_STATS_EN
  logic [15:0] a_grant_cnt;
  logic [15:0] b_grant_cnt;
  logic [15:0] conflict_cnt;
  logic        conflict;

  // A conflict needs an owner: the other port is requesting and is locked out
  assign conflict = ((state == OWN_A) && i_b_req) || ((state == OWN_B) && i_a_req);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_grant_cnt  <= '0;
      b_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else if (clk_en) begin
      if (a_gnt && (a_grant_cnt != 16'hFFFF)) begin
        a_grant_cnt <= a_grant_cnt + 16'd1;
      end
      if (b_gnt && (b_grant_cnt != 16'hFFFF)) begin
        b_grant_cnt <= b_grant_cnt + 16'd1;
      end
      if (conflict && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

  assign o_a_grant_count  = a_grant_cnt;
  assign o_b_grant_count  = b_grant_cnt;
  assign o_conflict_count = conflict_cnt;
`else
  // Statistics are compiled out; arbitration is unaffected.
`endif

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters. Port A is the CPU bus; port B is the front-panel/serial program loader.
- Grants at most one access per enabled clock. Drives the RAM address, load-enable and load-data inputs, and returns registered read data with a valid strobe.
- Round-robin arbitration, plus a bounded lock for back-to-back bursts.
- Sits between the SAP1 control/bus logic and the RAM instance.

Parameters:
- RAM_DEPTH, 16, number of RAM words
- WIDTH, 8, data width in bits
- MAX_LOCK, 4, max consecutive grants to a locked owner while the other port is requesting (≥1)
- ADDR_WIDTH, $clog2(RAM_DEPTH), localparam, address width

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- clk_en  input  1  global clock enable; all state advances only when high
- i_a_req / i_b_req  input  1  access request (held until granted)
- i_a_lock / i_b_lock  input  1  keep ownership for the next access (burst)
- i_a_we / i_b_we  input  1  1=write, 0=read
- i_a_addr / i_b_addr  input  ADDR_WIDTH  access address
- i_a_wdata / i_b_wdata  input  WIDTH  write data
- o_a_gnt / o_b_gnt  output  1  access performed this cycle
- o_a_rdata / o_b_rdata  output  WIDTH  registered read data
- o_a_rvalid / o_b_rvalid  output  1  rdata valid (one clk_en cycle)
- o_ram_address  output  ADDR_WIDTH  to RAM i_address
- o_ram_load_enable  output  1  to RAM i_load_enable
- o_ram_load_data  output  WIDTH  to RAM i_load_data
- i_ram_data  input  WIDTH  from RAM o_data (combinational read)

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-low, on rst_n, and applies regardless of clk_en.
- Reset values: state=IDLE, last_served=B (so A wins the first tie), lock_cnt=0, o_x_rdata=0, o_x_rvalid=0.
- States: IDLE, OWN_A, OWN_B.
- Transitions are evaluated only on clk_en=1 edges:
  - IDLE: both req → owner = port != last_served. One req → that port. None → IDLE.
  - OWN_X, own req high and lock high:
    - other req low → stay.
    - other req high → stay only while lock_cnt < MAX_LOCK-1, else switch to other.
  - OWN_X, own req high, lock low:
    - other req high → switch to other.
    - otherwise → stay.
  - OWN_X, own req low: other req → OWN_other, else → IDLE.
  - On every grant: last_served=X. lock_cnt increments on a stay-with-lock-while-contended, else clears to 0.
- Grant: o_x_gnt = (state==OWN_X) & i_x_req, combinational. Latency from req rising in IDLE to gnt is 1 enabled cycle. When ownership is switched the other way, the losing port waits.
- RAM drive:
  - o_ram_address = owner's addr. In IDLE it holds the last owner's addr.
  - o_ram_load_data = owner's wdata.
  - o_ram_load_enable = gnt_x & we_x (the RAM itself gates with clk_en).
- Read: on a granted read with clk_en=1, capture i_ram_data into o_x_rdata.
  - o_x_rvalid=1 for the next enabled cycle, cleared after. rdata holds until the next read.
  - Read latency: gnt cycle + 1.
- A write never asserts rvalid.
- The RAM is not write-through: a read after a write to the same addr in a later cycle returns the new data.
- clk_en=0: state, counters and rvalid are frozen. Gnt may show combinationally, but no access completes because the RAM is gated.
- A requester dropping req while owner releases on the next enabled edge; no access occurs.
- Reset mid-burst: ownership is lost, and a pending rvalid is cleared without delivery.

Optional Feature:
- Macro RAM_ARBITER_STATS_EN.
- Defined: adds outputs o_a_grant_count and o_b_grant_count, 16 bits each.
  - Each increments on every enabled grant and saturates at 16'hFFFF.
  - Adds output o_conflict_count, 16 bits, saturating: counts enabled cycles where the non-owner req is high and no grant goes to it.
  - All three clear on reset.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with both reqs high → all gnt/rvalid 0, state IDLE. First grant after release goes to A.
- Single write then read on B: write addr 3 data 8'h5A, then read addr 3 → o_b_gnt pulses; o_b_rvalid=1 with o_b_rdata=8'h5A one enabled cycle after the read gnt.
- Contention: A and B request continuously with no lock → grants alternate A,B,A,B. Each port reads back its own addresses correctly.
- Lock limit: A locked, B requesting, MAX_LOCK=4 → exactly 4 consecutive A grants, then B is granted.
- clk_en gating: hold clk_en=0 for 3 cycles mid-read → rvalid appears only after clk_en returns. The RAM contents at the write addr are unchanged while gated.
- With RAM_ARBITER_STATS_EN: 10 A grants, 6 B grants, 3 conflict cycles → counts 10/6/3. Saturation is checked by forcing 16'hFFFF and issuing one more grant → value stays 16'hFFFF.
